// File: rtl/audio_out_pkg.sv
// Shared constants and register layout for the audio output peripheral.
package audio_out_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned SAMPLE_W = 16;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_CLR = 1;

  // STAT bit positions that accept write-1-to-clear
  localparam int unsigned STAT_UNDERRUN = 2;
  localparam int unsigned STAT_OVERFLOW = 3;

  // Offset-binary mid-scale; also the sign-flip mask for two's complement samples
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  // STAT register image as seen on the read bus
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        underrun;
    logic        empty;
    logic        full;
  } stat_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push to a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout_c,
  output logic                         full_c,
  output logic                         empty_c,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush overrides both operations; a pop frees the slot a same-cycle push needs
  always_comb begin
    full_c  = (count == CW'(DEPTH));
    empty_c = (count == '0);
    do_pop  = pop && !empty_c && !flush;
    do_push = push && (!full_c || do_pop) && !flush;
    dout_c  = mem[rd_ptr];
  end

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_out_pio.sv
// Memory-mapped audio playback: sample FIFO, sample-rate timer and first-order delta-sigma DAC.
module audio_out_pio
  import audio_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DIV_RESET  = 1133
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [BUS_W-1:0] addr,
  input  logic [BUS_W-1:0] wd,
  output logic [BUS_W-1:0] rd,
  output logic             dac_out,
  output logic             sample_stb,
  output logic             irq_low
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  // Mid-scale scaled up to the sample width (DATA_W >= SAMPLE_W)
  localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE) << (DATA_W - SAMPLE_W);

  logic [1:0]        sel;
  logic              wr_ctrl;
  logic              wr_stat;
  logic              wr_data;
  logic              wr_div;
  logic              clr;

  logic              en;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  cnt;
  logic              tick;
  logic              pop_ok;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;
  logic              underrun;
  logic              overflow;
  logic              underrun_set;
  logic              overflow_set;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  stat_t             stat;
  logic [BUS_W-1:0]  rd_next;
  logic              unused;

  assign unused = ^{addr[31:4], addr[1:0], wd[31:16]};

  // Write decode and event qualification
  always_comb begin
    sel          = addr[3:2];
    wr_ctrl      = we && (sel == REG_CTRL);
    wr_stat      = we && (sel == REG_STAT);
    wr_data      = we && (sel == REG_DATA);
    wr_div       = we && (sel == REG_DIV);
    clr          = wr_ctrl && wd[CTRL_CLR];
    tick         = en && (cnt == '0);
    pop_ok       = tick && !fifo_empty && !clr;
    underrun_set = tick && fifo_empty;
    overflow_set = wr_data && !clr && fifo_full && !pop_ok;
    sum          = {1'b0, acc} + {1'b0, cur};
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (clr),
    .push    (wr_data && !clr),
    .din     (wd[DATA_W-1:0]),
    .pop     (pop_ok),
    .dout_c  (fifo_dout),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  // CTRL.EN and DIV registers; a zero period is clamped to one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en  <= 1'b0;
      div <= DIV_W'(DIV_RESET);
    end else begin
      if (wr_ctrl) begin
        en <= wd[CTRL_EN];
      end
      if (wr_div) begin
        div <= (wd[DIV_W-1:0] == '0) ? DIV_W'(1) : wd[DIV_W-1:0];
      end
    end
  end

  // Sample timer: held at DIV while disabled so enabling restarts a full period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= DIV_W'(DIV_RESET);
    end else if (!en || (cnt == '0)) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  // Current DAC code: popped sample in offset binary, mid-scale when idle or starved
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= MID;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= pop_ok;
      if (pop_ok) begin
        cur <= fifo_dout ^ MID;
      end else if (!en || tick) begin
        cur <= MID;
      end
    end
  end

  // Sticky status flags; a set event wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= (underrun && !(wr_stat && wd[STAT_UNDERRUN])) || underrun_set;
      overflow <= (overflow && !(wr_stat && wd[STAT_OVERFLOW])) || overflow_set;
    end
  end

  // First-order delta-sigma: the accumulator carry is the output bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      acc     <= sum[DATA_W-1:0];
      dac_out <= sum[DATA_W];
    end
  end

  // Low-water interrupt level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_low <= 1'b0;
    end else begin
      irq_low <= en && (fifo_count <= CW'(FIFO_DEPTH / 4));
    end
  end

  // Read mux; reads have no side effects
  always_comb begin
    stat          = '0;
    stat.full     = fifo_full;
    stat.empty    = fifo_empty;
    stat.underrun = underrun;
    stat.overflow = overflow;
    stat.count    = 8'(fifo_count);
    rd_next       = '0;
    case (sel)
      REG_CTRL: rd_next[CTRL_EN] = en;
      REG_STAT: rd_next = stat;
      REG_DIV:  rd_next = BUS_W'(div);
      default:  rd_next = '0;
    endcase
  end

  // Registered read data, valid one cycle after addr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd <= '0;
    end else begin
      rd <= rd_next;
    end
  end

endmodule

// File: tb/tb_audio_out_pio.sv
// Scoreboard bench for audio_out_pio: reads queue expected data, a monitor compares rd one cycle later.
module tb_audio_out_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        dac_out;
  logic        sample_stb;
  logic        irq_low;

  always #5 clk = ~clk;

  audio_out_pio #(
    .FIFO_DEPTH (16),
    .DATA_W     (16),
    .DIV_RESET  (1133)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we),
    .addr       (addr),
    .wd         (wd),
    .rd         (rd),
    .dac_out    (dac_out),
    .sample_stb (sample_stb),
    .irq_low    (irq_low)
  );

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_DATA = 32'h8;
  localparam logic [31:0] A_DIV  = 32'hC;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wr_time  = 0;
  logic        rd_req   = 1'b0;
  logic        rd_req_q = 1'b0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          stb_times [$];
  logic [31:0] mon_e;
  string       mon_n;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_q <= rd_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: records sample strobes and checks each read response against the queue
  always @(negedge clk) begin
    if (sample_stb) stb_times.push_back(cyc);
    if (rd_req_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected entry", rd);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check(mon_n, rd, mon_e);
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0;
    wr_time = cyc;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    addr = a; rd_req = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  int duty_lo [3] = '{255, 0, 128};
  int duty_hi [3] = '{256, 0, 128};
  logic [31:0] stb_exp [3] = '{32'd1, 32'd1, 32'd0};

  initial begin
    int   n;
    int   t0;
    int   ones;
    int   toggles;
    logic prev;

    reset_n = 1'b0; we = 1'b0; addr = A_DIV; wd = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", rd, 32'h0);
    check("rst_dac", 32'(dac_out), 32'h0);
    check("rst_stb", 32'(sample_stb), 32'h0);
    check("rst_irq", 32'(irq_low), 32'h0);
    reset_n = 1'b1;

    // Reset register values
    bus_read(A_DIV,  32'd1133, "div_reset");
    bus_read(A_STAT, 32'h0002, "stat_reset");
    bus_read(A_CTRL, 32'h0000, "ctrl_reset");
    bus_read(A_DATA, 32'h0000, "data_reads_zero");

    // Fill past full, overflow W1C, flush
    bus_write(A_DIV, 32'd3);
    bus_read(A_DIV, 32'd3, "div_wr3");
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'(i * 257));
    bus_read(A_STAT, 32'h1009, "stat_full_ovf");
    bus_write(A_STAT, 32'h8);
    bus_read(A_STAT, 32'h1001, "stat_ovf_w1c");
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STAT, 32'h0002, "stat_after_clr");
    bus_read(A_CTRL, 32'h0000, "ctrl_clr_reads0");

    // Playback cadence with DIV=3
    bus_write(A_DATA, 32'h7FFF);
    bus_write(A_DATA, 32'h8000);
    bus_write(A_DATA, 32'h0000);
    bus_read(A_STAT, 32'h0300, "stat_count3");
    stb_times.delete();
    bus_write(A_CTRL, 32'h1);
    t0 = wr_time;
    n = 0;
    while (stb_times.size() < 3 && n < 40) begin @(negedge clk); n++; end
    check("stb_count", 32'(stb_times.size()), 32'd3);
    if (stb_times.size() >= 3) begin
      check("stb_first_latency", 32'(stb_times[0] - t0), 32'd4);
      check("stb_period_1", 32'(stb_times[1] - stb_times[0]), 32'd4);
      check("stb_period_2", 32'(stb_times[2] - stb_times[1]), 32'd4);
    end
    repeat (8) @(negedge clk);
    check("stb_none_when_empty", 32'(stb_times.size()), 32'd3);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STAT, 32'h0006, "stat_underrun_a");
    bus_write(A_STAT, 32'h4);
    bus_read(A_STAT, 32'h0002, "stat_underrun_w1c");

    // Duty cycle per sample with a 256-cycle period
    bus_write(A_DIV, 32'd255);
    bus_write(A_DATA, 32'h7FFF);
    bus_write(A_DATA, 32'h8000);
    bus_write(A_DATA, 32'h0000);
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_low_enabled", 32'(irq_low), 32'd1);
    n = 0;
    while (!sample_stb && n < 300) begin @(negedge clk); n++; end
    check("stb_first_b", 32'(sample_stb), 32'd1);
    for (int s = 0; s < 3; s++) begin
      ones = 0;
      repeat (256) begin @(negedge clk); ones += int'(dac_out); end
      check_range($sformatf("duty_sample%0d", s), ones, duty_lo[s], duty_hi[s]);
      check($sformatf("stb_after_sample%0d", s), 32'(sample_stb), stb_exp[s]);
    end
    prev = dac_out;
    toggles = 0;
    repeat (8) begin
      @(negedge clk);
      if (dac_out != prev) toggles++;
      prev = dac_out;
    end
    check("dac_midscale_toggle", 32'(toggles), 32'd8);
    bus_read(A_STAT, 32'h0006, "stat_underrun_b");
    bus_write(A_CTRL, 32'h0);
    repeat (2) @(negedge clk);
    check("irq_low_disabled", 32'(irq_low), 32'd0);
    bus_write(A_STAT, 32'h4);
    bus_read(A_STAT, 32'h0002, "stat_clear_b");

    // Corners: DIV clamp, flush drops contents, push+pop on full
    bus_write(A_DIV, 32'd0);
    bus_read(A_DIV, 32'd1, "div_clamp");
    bus_write(A_DATA, 32'h1);
    bus_write(A_DATA, 32'h2);
    bus_read(A_STAT, 32'h0200, "stat_count2");
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STAT, 32'h0002, "stat_flush");
    for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'(i));
    bus_read(A_STAT, 32'h1001, "stat_full16");
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    we = 1'b1; addr = A_DATA; wd = 32'h1234;
    @(negedge clk);
    addr = A_CTRL; wd = 32'h0;
    @(negedge clk);
    we = 1'b0;
    bus_read(A_STAT, 32'h1001, "stat_full_pushpop");

    // Asynchronous reset during playback
    bus_write(A_DIV, 32'd3);
    bus_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    addr = A_DIV;
    @(negedge clk);
    check("pre_reset_rd", rd, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rd", rd, 32'h0);
    check("async_rst_dac", 32'(dac_out), 32'h0);
    check("async_rst_stb", 32'(sample_stb), 32'h0);
    check("async_rst_irq", 32'(irq_low), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_STAT, 32'h0002, "stat_after_async_rst");
    bus_read(A_DIV,  32'd1133, "div_after_async_rst");
    bus_read(A_CTRL, 32'h0000, "ctrl_after_async_rst");

    repeat (4) @(negedge clk);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
